// File: rtl/tlb_search_arbiter.sv
// tlb_search_arbiter: shares one TLB search port between I and D MMUs, D first, I after STARVE_LIMIT denials; `MICRO_ITLB_EN adds a 1-entry I micro-TLB.
// Latency: accept in N, s_* driven in N+1, resp_valid in N+2; each tlb_wr cycle over a pending search adds one cycle.
// Backpressure: ready is combinational, no port grant while tlb_wr=1, the losing requester holds its payload.
module tlb_search_arbiter #(
  parameter int TLBNUM       = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_req,
  input  logic [18:0]               i_vpn,
  input  logic                      i_odd,
  output logic                      i_ready,
  output logic                      i_resp_valid,
  output logic                      i_found,
  output logic [$clog2(TLBNUM)-1:0] i_index,
  output logic [19:0]               i_pfn,
  output logic [2:0]                i_c,
  output logic                      i_d,
  output logic                      i_v,
  input  logic                      d_req,
  input  logic [18:0]               d_vpn,
  input  logic                      d_odd,
  output logic                      d_ready,
  output logic                      d_resp_valid,
  output logic                      d_found,
  output logic [$clog2(TLBNUM)-1:0] d_index,
  output logic [19:0]               d_pfn,
  output logic [2:0]                d_c,
  output logic                      d_d,
  output logic                      d_v,
  input  logic [7:0]                asid,
  input  logic                      tlb_wr,
  output logic [18:0]               s_vpn,
  output logic                      s_odd,
  output logic [7:0]                s_asid,
  input  logic                      s_found,
  input  logic [$clog2(TLBNUM)-1:0] s_index,
  input  logic [19:0]               s_pfn,
  input  logic [2:0]                s_c,
  input  logic                      s_d,
  input  logic                      s_v
);
  localparam int IW = $clog2(TLBNUM);
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef struct packed {
    logic          found;
    logic [IW-1:0] index;
    logic [19:0]   pfn;
    logic [2:0]    c;
    logic          d;
    logic          v;
  } res_t;

  typedef struct packed {
    logic        vld;
    logic        src_d;
    logic [18:0] vpn;
    logic        odd;
    logic [7:0]  asid;
  } s1_t;

  s1_t        s1_q, s1_nxt;
  res_t       s_res, i_res_q, d_res_q, u_pipe_res;
  logic       i_resp_vld_q, d_resp_vld_q, u_pipe_vld;
  logic [3:0] starve_cnt;
  logic       i_hit, i_prio, port_i, port_d, cap;

  assign s_res = {s_found, s_index, s_pfn, s_c, s_d, s_v};
  assign cap   = s1_q.vld && !tlb_wr;

  always_comb begin
    i_prio  = (starve_cnt == LIMIT);
    port_i  = !rst && !tlb_wr && i_req && !i_hit && (!d_req || i_prio);
    port_d  = !rst && !tlb_wr && d_req && !(i_req && !i_hit && i_prio);
    i_ready = port_i || i_hit;
    d_ready = port_d;
  end

  // S1 holds over a TLB write so the search is repeated against the new contents.
  always_comb begin
    s1_nxt = '0;
    if (port_d)
      s1_nxt = '{vld: 1'b1, src_d: 1'b1, vpn: d_vpn, odd: d_odd, asid: asid};
    else if (port_i)
      s1_nxt = '{vld: 1'b1, src_d: 1'b0, vpn: i_vpn, odd: i_odd, asid: asid};
    else if (tlb_wr)
      s1_nxt = s1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q         <= '0;
      starve_cnt   <= '0;
      i_resp_vld_q <= 1'b0;
      d_resp_vld_q <= 1'b0;
      i_res_q      <= '0;
      d_res_q      <= '0;
    end else begin
      s1_q         <= s1_nxt;
      i_resp_vld_q <= (cap && !s1_q.src_d) || u_pipe_vld;
      d_resp_vld_q <= cap && s1_q.src_d;
      if (cap && !s1_q.src_d)
        i_res_q <= s_res;
      else if (u_pipe_vld)
        i_res_q <= u_pipe_res;
      if (cap && s1_q.src_d)
        d_res_q <= s_res;
      if (!i_req || i_ready)
        starve_cnt <= '0;
      else if (starve_cnt != LIMIT)
        starve_cnt <= starve_cnt + 4'd1;
    end
  end

`ifdef MICRO_ITLB_EN
  logic        u_vld;
  logic [18:0] u_vpn;
  logic        u_odd;
  logic [7:0]  u_asid;
  res_t        u_res;

  assign i_hit = !rst && !tlb_wr && i_req && u_vld &&
                 (u_vpn == i_vpn) && (u_odd == i_odd) && (u_asid == asid);

  // A hit skips the port but still answers in N+2 through a one-stage pipe.
  always_ff @(posedge clk) begin
    if (rst) begin
      u_vld      <= 1'b0;
      u_vpn      <= '0;
      u_odd      <= 1'b0;
      u_asid     <= '0;
      u_res      <= '0;
      u_pipe_vld <= 1'b0;
      u_pipe_res <= '0;
    end else begin
      u_pipe_vld <= i_hit;
      u_pipe_res <= u_res;
      if (cap && !s1_q.src_d && s_found && s_v) begin
        u_vld  <= 1'b1;
        u_vpn  <= s1_q.vpn;
        u_odd  <= s1_q.odd;
        u_asid <= s1_q.asid;
        u_res  <= s_res;
      end else if (tlb_wr || (u_asid != asid)) begin
        u_vld <= 1'b0;
      end
    end
  end
`else
  assign i_hit      = 1'b0;
  assign u_pipe_vld = 1'b0;
  assign u_pipe_res = '0;
`endif

  assign s_vpn  = s1_q.vpn;
  assign s_odd  = s1_q.odd;
  assign s_asid = s1_q.asid;

  assign i_resp_valid = i_resp_vld_q;
  assign d_resp_valid = d_resp_vld_q;
  assign {i_found, i_index, i_pfn, i_c, i_d, i_v} = i_res_q;
  assign {d_found, d_index, d_pfn, d_c, d_d, d_v} = d_res_q;
endmodule

// File: tb/tb_tlb_search_arbiter.sv
// Bench for tlb_search_arbiter: acts as the TLB array, runs directed cases then random traffic against a cycle-indexed model.
module tb_tlb_search_arbiter;
  localparam int LIMIT = 4;
  localparam int IW    = 4;

  typedef struct packed {
    logic          found;
    logic [IW-1:0] index;
    logic [19:0]   pfn;
    logic [2:0]    c;
    logic          d;
    logic          v;
  } res_t;

  typedef struct {
    bit          src_d;
    logic [18:0] vpn;
    logic        odd;
    logic [7:0]  asid;
  } srch_t;

  logic clk = 1'b0;
  logic rst, i_req, i_odd, d_req, d_odd, tlb_wr;
  logic [18:0] i_vpn, d_vpn, s_vpn;
  logic [7:0]  asid, s_asid;
  logic i_ready, i_resp_valid, i_found, i_d, i_v;
  logic d_ready, d_resp_valid, d_found, d_d, d_v;
  logic [IW-1:0] i_index, d_index, s_index;
  logic [19:0] i_pfn, d_pfn, s_pfn;
  logic [2:0]  i_c, d_c, s_c;
  logic s_odd, s_found, s_d, s_v;

  always #5 clk = ~clk;

  tlb_search_arbiter #(.TLBNUM(16), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_vpn(i_vpn), .i_odd(i_odd), .i_ready(i_ready), .i_resp_valid(i_resp_valid),
    .i_found(i_found), .i_index(i_index), .i_pfn(i_pfn), .i_c(i_c), .i_d(i_d), .i_v(i_v),
    .d_req(d_req), .d_vpn(d_vpn), .d_odd(d_odd), .d_ready(d_ready), .d_resp_valid(d_resp_valid),
    .d_found(d_found), .d_index(d_index), .d_pfn(d_pfn), .d_c(d_c), .d_d(d_d), .d_v(d_v),
    .asid(asid), .tlb_wr(tlb_wr), .s_vpn(s_vpn), .s_odd(s_odd), .s_asid(s_asid),
    .s_found(s_found), .s_index(s_index), .s_pfn(s_pfn), .s_c(s_c), .s_d(s_d), .s_v(s_v)
  );

  int gen = 0;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit chk_en = 0;

  // TLB contents: a few pinned translations, the rest a hash that moves with every write.
  function automatic res_t lookup(logic [18:0] vpn, logic odd, logic [7:0] a, int g);
    res_t r;
    logic [31:0] h;
    h = ({4'h0, vpn, odd, a} + 32'(g) * 32'h0100_0193) * 32'h9E37_79B1;
    r.found = (h[31:30] != 2'b00);
    r.index = h[27:24];
    r.pfn   = h[19:0];
    r.c     = h[22:20];
    r.d     = h[23];
    r.v     = h[29] | h[28];
    if (vpn == 19'h1 || vpn == 19'h2 || vpn == 19'h3 || vpn == 19'h40) begin
      r.found = 1'b1;
      r.v     = 1'b1;
      r.index = 4'h3;
      r.c     = 3'd3;
      r.d     = 1'b1;
      case (vpn)
        19'h1:   r.pfn = 20'h12345;
        19'h2:   r.pfn = 20'h0A000 | 20'(g & 255);
        19'h3:   r.pfn = 20'h00333;
        default: r.pfn = 20'h40040;
      endcase
    end
    return r;
  endfunction

  res_t tlb_r;
  always_comb tlb_r = lookup(s_vpn, s_odd, s_asid, gen);
  assign {s_found, s_index, s_pfn, s_c, s_d, s_v} = tlb_r;

  logic [29:0] i_res_w, d_res_w;
  assign i_res_w = {i_found, i_index, i_pfn, i_c, i_d, i_v};
  assign d_res_w = {d_found, d_index, d_pfn, d_c, d_d, d_v};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: searches waiting for a write-free port cycle, responses keyed by the cycle they must appear in.
  int    starve = 0;
  srch_t inflight[$];
  res_t  exp_i[int];
  res_t  exp_d[int];
  res_t  last_i = '0;
  res_t  last_d = '0;
  bit          u_vld = 0;
  logic [18:0] u_vpn = '0;
  logic        u_odd = 1'b0;
  logic [7:0]  u_asid = '0;
  res_t        u_res = '0;

  always @(negedge clk) begin : compare
    bit hit, ie, de, iv, dv, filled;
    srch_t h;
    res_t r;
    if (chk_en) begin
      hit = 0;
`ifdef MICRO_ITLB_EN
      hit = u_vld && i_req && !tlb_wr && !rst && u_vpn == i_vpn && u_odd == i_odd && u_asid == asid;
`endif
      ie = !rst && !tlb_wr && i_req && (hit || !d_req || starve == LIMIT);
      de = !rst && !tlb_wr && d_req && !(i_req && !hit && starve == LIMIT);
      chk("i_ready", 64'(i_ready), 64'(ie));
      chk("d_ready", 64'(d_ready), 64'(de));
      h = '{1'b0, 19'h0, 1'b0, 8'h0};
      if (inflight.size() > 0) h = inflight[0];
      chk("s_port", 64'({s_vpn, s_odd, s_asid}), 64'({h.vpn, h.odd, h.asid}));
      iv = exp_i.exists(cyc);
      if (iv) begin last_i = exp_i[cyc]; exp_i.delete(cyc); end
      dv = exp_d.exists(cyc);
      if (dv) begin last_d = exp_d[cyc]; exp_d.delete(cyc); end
      chk("i_resp_valid", 64'(i_resp_valid), 64'(iv));
      chk("d_resp_valid", 64'(d_resp_valid), 64'(dv));
      chk("i_result", 64'(i_res_w), 64'(last_i));
      chk("d_result", 64'(d_res_w), 64'(last_d));
      if (rst) begin
        inflight.delete();
        exp_i.delete();
        exp_d.delete();
        starve = 0;
        u_vld  = 0;
        last_i = '0;
        last_d = '0;
      end else begin
        filled = 0;
        if (ie && hit) exp_i[cyc + 2] = u_res;
        if (inflight.size() > 0 && !tlb_wr) begin
          h = inflight.pop_front();
          r = lookup(h.vpn, h.odd, h.asid, gen);
          if (h.src_d) exp_d[cyc + 1] = r;
          else begin
            exp_i[cyc + 1] = r;
            if (r.found && r.v) begin
              u_vld = 1; u_vpn = h.vpn; u_odd = h.odd; u_asid = h.asid; u_res = r;
              filled = 1;
            end
          end
        end
        if (de) inflight.push_back('{1'b1, d_vpn, d_odd, asid});
        if (ie && !hit) inflight.push_back('{1'b0, i_vpn, i_odd, asid});
        starve = (i_req && !ie) ? ((starve < LIMIT) ? starve + 1 : LIMIT) : 0;
        if (!filled && (tlb_wr || u_asid != asid)) u_vld = 0;
      end
      if (tlb_wr) gen++;
      cyc++;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    i_req = 0; d_req = 0; tlb_wr = 0;
    repeat (n) next_cycle();
  endtask

  function automatic logic [18:0] pick_vpn();
    case ($urandom_range(7))
      0: return 19'h1;
      1: return 19'h2;
      2: return 19'h3;
      3: return 19'h40;
      default: return 19'($urandom_range(15));
    endcase
  endfunction

  initial begin : driver
    bit ia, da;
    string pat;
    logic [19:0] t6_exp [3];
    rst = 1; i_req = 0; d_req = 0; tlb_wr = 0; asid = 8'h05;
    i_vpn = '0; d_vpn = '0; i_odd = 0; d_odd = 0;
    next_cycle();
    chk_en = 1;
    // Reset: requests pending, everything still low.
    i_req = 1; d_req = 1; i_vpn = 19'h10; d_vpn = 19'h11;
    @(negedge clk);
    chk("rst_ctrl", 64'({i_ready, d_ready, i_resp_valid, d_resp_valid, s_vpn, s_odd, s_asid}), 64'(0));
    chk("rst_i_res", 64'(i_res_w), 64'(0));
    chk("rst_d_res", 64'(d_res_w), 64'(0));
    next_cycle();
    rst = 0;
    @(negedge clk);
    chk("exit_d_wins", 64'({i_ready, d_ready}), 64'(2'b01));
    next_cycle();
    d_req = 0;
    @(negedge clk);
    chk("exit_i_next", 64'(i_ready), 64'(1));
    next_cycle();
    idle(4);

    // Single I search through the port.
    i_req = 1; i_vpn = 19'h1; i_odd = 0;
    @(negedge clk);
    chk("t1_i_ready", 64'(i_ready), 64'(1));
    next_cycle();
    i_req = 0;
    @(negedge clk);
    chk("t1_s_vpn", 64'(s_vpn), 64'(19'h1));
    @(negedge clk);
    chk("t1_resp", 64'({i_resp_valid, i_pfn}), 64'({1'b1, 20'h12345}));
    next_cycle();
    idle(3);

    // Starvation guard with both requesters saturating.
    pat = "DDDDIDDDDI";
    i_req = 1; d_req = 1; i_vpn = 19'h100; d_vpn = 19'h200;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t2_grant", 64'({i_ready, d_ready}), (pat[k] == "I") ? 64'(2'b10) : 64'(2'b01));
      ia = i_ready; da = d_ready;
      next_cycle();
      if (ia) i_vpn = i_vpn + 19'h1;
      if (da) d_vpn = d_vpn + 19'h1;
    end
    idle(4);

    // A TLB write right after grant forces a re-search.
    d_req = 1; d_vpn = 19'h2;
    @(negedge clk);
    chk("t3_d_ready", 64'(d_ready), 64'(1));
    next_cycle();
    tlb_wr = 1; d_vpn = 19'h3;
    @(negedge clk);
    chk("t3_no_grant", 64'(d_ready), 64'(0));
    chk("t3_s_vpn_wr", 64'(s_vpn), 64'(19'h2));
    next_cycle();
    tlb_wr = 0; d_req = 0;
    @(negedge clk);
    chk("t3_s_vpn_rep", 64'(s_vpn), 64'(19'h2));
    chk("t3_no_resp_yet", 64'(d_resp_valid), 64'(0));
    @(negedge clk);
    chk("t3_resp", 64'({d_resp_valid, d_pfn}), 64'({1'b1, 20'h0A001}));
    next_cycle();
    idle(3);

    // Back-to-back D grants answer in order.
    t6_exp = '{20'h12345, 20'h0A001, 20'h00333};
    for (int t = 0; t < 5; t++) begin
      d_req = (t < 3);
      d_vpn = 19'(t + 1);
      @(negedge clk);
      if (t < 3) chk("t6_d_ready", 64'(d_ready), 64'(1));
      if (t >= 2) chk("t6_resp", 64'({d_resp_valid, d_pfn}), 64'({1'b1, t6_exp[t - 2]}));
      next_cycle();
    end
    idle(3);

`ifdef MICRO_ITLB_EN
    // Micro-TLB: fill, concurrent bypass with D, then asid change removes it.
    i_req = 1; i_vpn = 19'h40; i_odd = 0;
    @(negedge clk);
    chk("t5_fill_grant", 64'(i_ready), 64'(1));
    next_cycle();
    idle(3);
    i_req = 1; i_vpn = 19'h40; d_req = 1; d_vpn = 19'h1;
    @(negedge clk);
    chk("t5_both_ready", 64'({i_ready, d_ready}), 64'(2'b11));
    next_cycle();
    i_req = 0; d_req = 0;
    @(negedge clk);
    @(negedge clk);
    chk("t5_both_resp", 64'({i_resp_valid, d_resp_valid, i_pfn, d_pfn}),
        64'({2'b11, 20'h40040, 20'h12345}));
    next_cycle();
    asid = 8'h06;
    idle(1);
    i_req = 1; d_req = 1;
    @(negedge clk);
    chk("t5_no_bypass", 64'({i_ready, d_ready}), 64'(2'b01));
    next_cycle();
    d_req = 0;
    @(negedge clk);
    chk("t5_i_port", 64'(i_ready), 64'(1));
    next_cycle();
    idle(3);
`endif

    // Reset one cycle after a grant drops the search.
    i_req = 1; i_vpn = 19'h55;
    @(negedge clk);
    chk("t4_grant", 64'(i_ready), 64'(1));
    next_cycle();
    i_req = 0; rst = 1;
    next_cycle();
    rst = 0;
    @(negedge clk);
    chk("t4_ctrl_zero", 64'({i_ready, d_ready, i_resp_valid, d_resp_valid, s_vpn, s_odd, s_asid}), 64'(0));
    chk("t4_res_zero", 64'({i_res_w, d_res_w}), 64'(0));
    next_cycle();
    @(negedge clk);
    chk("t4_no_resp", 64'({i_resp_valid, d_resp_valid}), 64'(0));
    next_cycle();

    // Random traffic; requesters hold payload until accepted.
    ia = 0; da = 0;
    for (int n = 0; n < 3000; n++) begin
      if (rst) rst = 0;
      else rst = ($urandom_range(99) < 1);
      tlb_wr = !rst && ($urandom_range(99) < 10);
      if ($urandom_range(99) < 4) asid = 8'($urandom_range(3));
      if (!i_req || ia) begin
        i_req = ($urandom_range(99) < 60);
        i_vpn = pick_vpn();
        i_odd = ($urandom_range(3) == 0);
      end
      if (!d_req || da) begin
        d_req = ($urandom_range(99) < 60);
        d_vpn = pick_vpn();
        d_odd = ($urandom_range(3) == 0);
      end
      @(negedge clk);
      ia = i_req && i_ready;
      da = d_req && d_ready;
      next_cycle();
    end
    rst = 0;
    idle(5);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
